// File: rtl/muldiv_sched.sv
// Sequencing controller for the shared multiply/divide units; owns the architectural HI/LO registers.
// Optional feature: define DIVZERO_CHECK_EN to short-circuit DIV by zero and expose the div_zero pulse.
module muldiv_sched #(
    parameter int TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [1:0]  op_code,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        op_ready,
    output logic        busy,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    output logic        mult_start,
    input  logic        mult_end,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    output logic        div_start,
    input  logic        div_end,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        done,
    output logic        timeout_err,
`ifdef DIVZERO_CHECK_EN
    output logic        div_zero,
`endif
    output logic [2:0]  dbg_state
);

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MTHI = 2'b10;
    localparam logic [1:0] OP_MTLO = 2'b11;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_ARM   = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [31:0]     unit_a_q, unit_a_d;
    logic [31:0]     unit_b_q, unit_b_d;
    logic [31:0]     hi_q, hi_d;
    logic [31:0]     lo_q, lo_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            tmo_d;
    logic            op_ready_q, mult_start_q, div_start_q, done_q, timeout_err_q;
    logic            sel_end;
    logic [31:0]     sel_hi, sel_lo;
`ifdef DIVZERO_CHECK_EN
    logic            dz_d, div_zero_q;
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        unit_a_d = unit_a_q;
        unit_b_d = unit_b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        tmo_d    = 1'b0;
`ifdef DIVZERO_CHECK_EN
        dz_d     = 1'b0;
`endif
        // Only the unit that was started is allowed to complete the operation.
        sel_end  = (op_q == OP_DIV) ? div_end : mult_end;
        sel_hi   = (op_q == OP_DIV) ? div_hi  : mult_hi;
        sel_lo   = (op_q == OP_DIV) ? div_lo  : mult_lo;

        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    unit_a_d = op_a;
                    unit_b_d = op_b;
                    op_d     = op_code;
                    case (op_code)
                        OP_MTHI: begin
                            hi_d    = op_a;
                            state_d = S_DONE;
                        end
                        OP_MTLO: begin
                            lo_d    = op_a;
                            state_d = S_DONE;
                        end
`ifdef DIVZERO_CHECK_EN
                        OP_DIV: begin
                            if (op_b == 32'd0) begin
                                dz_d    = 1'b1;
                                state_d = S_DONE;
                            end else begin
                                state_d = S_START;
                            end
                        end
`endif
                        default: state_d = S_START;
                    endcase
                end
            end
            S_START: state_d = S_ARM;
            // End flags are ignored here: a level left from the previous op may still be up.
            S_ARM: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (sel_end) begin
                    hi_d    = sel_hi;
                    lo_d    = sel_lo;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(TIMEOUT - 1)) begin
                        tmo_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            op_q          <= OP_MULT;
            unit_a_q      <= '0;
            unit_b_q      <= '0;
            hi_q          <= '0;
            lo_q          <= '0;
            cnt_q         <= '0;
            op_ready_q    <= 1'b1;
            mult_start_q  <= 1'b0;
            div_start_q   <= 1'b0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            unit_a_q      <= unit_a_d;
            unit_b_q      <= unit_b_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            cnt_q         <= cnt_d;
            op_ready_q    <= (state_d == S_IDLE);
            mult_start_q  <= (state_d == S_START) && (op_d == OP_MULT);
            div_start_q   <= (state_d == S_START) && (op_d == OP_DIV);
            done_q        <= (state_d == S_DONE);
            timeout_err_q <= tmo_d;
        end
    end

`ifdef DIVZERO_CHECK_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) div_zero_q <= 1'b0;
        else       div_zero_q <= dz_d;
    end
    assign div_zero = div_zero_q;
`endif

    assign op_ready    = op_ready_q;
    assign busy        = ~op_ready_q;
    assign unit_a      = unit_a_q;
    assign unit_b      = unit_b_q;
    assign mult_start  = mult_start_q;
    assign div_start   = div_start_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign done        = done_q;
    assign timeout_err = timeout_err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_muldiv_sched.sv
// Bench for muldiv_sched: behavioural multiplier/divider models, a transaction-level HI/LO model
// and cycle expectations taken from the accept-relative timing rules.
module tb_muldiv_sched;

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MTHI = 2'b10;
    localparam logic [1:0] OP_MTLO = 2'b11;
    localparam int MULT_LAT = 32;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        op_valid = 1'b0, op_valid_t = 1'b0;
    logic [1:0]  op_code = 2'b00;
    logic [31:0] op_a = '0, op_b = '0;

    logic        op_ready, busy, mult_start, div_start, done, timeout_err;
    logic [31:0] unit_a, unit_b, hi, lo;
    logic [2:0]  dbg_state;
    logic        m_end = 1'b0, d_end = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0, d_hi = '0, d_lo = '0;

    logic        op_ready_t, busy_t, mult_start_t, div_start_t, done_t, timeout_err_t;
    logic [31:0] unit_a_t, unit_b_t, hi_t, lo_t;
    logic [2:0]  dbg_state_t;
    logic        tie_end = 1'b0;
    logic [31:0] tie_word = '0;
`ifdef DIVZERO_CHECK_EN
    logic        div_zero, div_zero_t;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int d_lat    = 1;
    int m_cnt    = 0, d_cnt = 0;
    logic [31:0] mdl_hi = '0, mdl_lo = '0;
    logic [63:0] exp_q[$];

    muldiv_sched #(.TIMEOUT(64)) u_dut (
        .clock(clock), .reset(reset), .op_valid(op_valid), .op_code(op_code),
        .op_a(op_a), .op_b(op_b), .op_ready(op_ready), .busy(busy),
        .unit_a(unit_a), .unit_b(unit_b), .mult_start(mult_start), .mult_end(m_end),
        .mult_hi(m_hi), .mult_lo(m_lo), .div_start(div_start), .div_end(d_end),
        .div_hi(d_hi), .div_lo(d_lo), .hi(hi), .lo(lo), .done(done),
        .timeout_err(timeout_err),
`ifdef DIVZERO_CHECK_EN
        .div_zero(div_zero),
`endif
        .dbg_state(dbg_state)
    );

    muldiv_sched #(.TIMEOUT(8)) u_dut_t (
        .clock(clock), .reset(reset), .op_valid(op_valid_t), .op_code(op_code),
        .op_a(op_a), .op_b(op_b), .op_ready(op_ready_t), .busy(busy_t),
        .unit_a(unit_a_t), .unit_b(unit_b_t), .mult_start(mult_start_t), .mult_end(tie_end),
        .mult_hi(tie_word), .mult_lo(tie_word), .div_start(div_start_t), .div_end(tie_end),
        .div_hi(tie_word), .div_lo(tie_word), .hi(hi_t), .lo(lo_t), .done(done_t),
        .timeout_err(timeout_err_t),
`ifdef DIVZERO_CHECK_EN
        .div_zero(div_zero_t),
`endif
        .dbg_state(dbg_state_t)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference arithmetic ----------------
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = int'(a);
        sb = int'(b);
        return 64'(sa * sb);
    endfunction

    // Returns {remainder, quotient}; a zero divisor yields {a, all ones}.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        int sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        sa = int'(a);
        sb = int'(b);
        q  = sa / sb;
        r  = sa % sb;
        return {32'(r), 32'(q)};
    endfunction

    // ---------------- unit models ----------------
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_cnt <= 0; m_end <= 1'b0; m_hi <= '0; m_lo <= '0;
        end else if (mult_start) begin
            m_cnt <= MULT_LAT; m_end <= 1'b0;
            {m_hi, m_lo} <= ref_mul(unit_a, unit_b);
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) m_end <= 1'b1;
        end
    end

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            d_cnt <= 0; d_end <= 1'b0; d_hi <= '0; d_lo <= '0;
        end else if (div_start) begin
            d_cnt <= d_lat; d_end <= 1'b0;
            {d_hi, d_lo} <= ref_div(unit_a, unit_b);
        end else if (d_cnt != 0) begin
            d_cnt <= d_cnt - 1;
            if (d_cnt == 1) d_end <= 1'b1;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- driver: one op through the main instance ----------------
    task automatic do_op(input logic [1:0] code, input logic [31:0] a, input logic [31:0] b,
                         input int lat);
        int k, c0, guard, done_at, n_done, ms, ds, dz, exp_dz, lk;
        logic [63:0] pair, got_pair;
        logic exp_ms, exp_ds;
        d_lat = lat;
        guard = 0;
        @(negedge clock);
        while (!op_ready && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        check("ready_wait", op_ready, 1);
        op_valid = 1'b1; op_code = code; op_a = a; op_b = b;
        @(posedge clock); #1;
        op_valid = 1'b0;
        c0 = cyc;

        exp_ms = 1'b0; exp_ds = 1'b0; exp_dz = 0;
        case (code)
            OP_MULT: begin
                lk = (1 + MULT_LAT > 2) ? 1 + MULT_LAT : 2;
                k = lk + 1; pair = ref_mul(a, b); exp_ms = 1'b1;
            end
            OP_DIV: begin
                lk = (1 + lat > 2) ? 1 + lat : 2;
                k = lk + 1; pair = ref_div(a, b); exp_ds = 1'b1;
`ifdef DIVZERO_CHECK_EN
                if (b == 32'd0) begin
                    k = 0; pair = {mdl_hi, mdl_lo}; exp_ds = 1'b0; exp_dz = 1;
                end
`endif
            end
            OP_MTHI: begin k = 0; pair = {a, mdl_lo}; end
            default: begin k = 0; pair = {mdl_hi, b == b ? a : a}; pair = {mdl_hi, a}; end
        endcase
        exp_q.push_back(pair);

        done_at = -1; n_done = 0; ms = 0; ds = 0; dz = 0;
        for (int i = 0; i <= k + 4; i++) begin
            @(negedge clock);
            ms += int'(mult_start);
            ds += int'(div_start);
`ifdef DIVZERO_CHECK_EN
            dz += int'(div_zero);
`endif
            if (done) begin
                n_done++;
                if (done_at < 0) done_at = cyc;
            end
        end
        check("done_cycle", done_at, c0 + k);
        check("done_count", n_done, 1);
        check("mult_starts", ms, int'(exp_ms));
        check("div_starts", ds, int'(exp_ds));
        check("div_zero", dz, exp_dz);
        got_pair = {hi, lo};
        check("hilo", got_pair, exp_q.pop_front());
        {mdl_hi, mdl_lo} = pair;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c0, done_a, done_b, n_done, ms, ds, n_tmo, tmo_at, early;
        logic [1:0] code;
        logic [31:0] a, b;

        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_state", dbg_state, 0);
        check("rst_ready", op_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_units", {unit_a, unit_b}, 64'd0);
        check("rst_pulses", {mult_start, div_start, done, timeout_err}, 0);
`ifdef DIVZERO_CHECK_EN
        check("rst_dz", div_zero, 0);
`endif

        // Directed MULT and DIV
        do_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, 1);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);
        do_op(OP_DIV, 32'd100, 32'd7, 10);
        check("div_hi", hi, 32'd2);
        check("div_lo", lo, 32'd14);
        do_op(OP_DIV, 32'd55, 32'hFFFF_FFF9, 1);
        do_op(OP_DIV, 32'd1234, 32'd0, 5);

        // MTHI then MTLO, the second held while busy
        @(negedge clock);
        op_valid = 1'b1; op_code = OP_MTHI; op_a = 32'h1234_5678;
        @(posedge clock); #1;
        c0 = cyc;
        op_code = OP_MTLO; op_a = 32'h9ABC_DEF0;
        done_a = -1; done_b = -1; n_done = 0; ms = 0; ds = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            ms += int'(mult_start);
            ds += int'(div_start);
            if (cyc == c0) check("mthi_hi", hi, 32'h1234_5678);
            if (cyc == c0 + 1) check("mtlo_not_yet", lo, mdl_lo);
            if (done) begin
                n_done++;
                if (done_a < 0) done_a = cyc;
                else begin
                    done_b = cyc;
                    op_valid = 1'b0;
                end
            end
        end
        check("mthi_done", done_a, c0);
        check("mtlo_done", done_b, c0 + 2);
        check("mt_done_count", n_done, 2);
        check("mt_starts", ms + ds, 0);
        check("mt_hilo", {hi, lo}, {32'h1234_5678, 32'h9ABC_DEF0});
        mdl_hi = 32'h1234_5678; mdl_lo = 32'h9ABC_DEF0;

        // Randomized ops
        for (int n = 0; n < 30; n++) begin
            code = 2'($urandom_range(0, 3));
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            do_op(code, a, b, $urandom_range(1, 12));
        end

        // Timeout on the TIMEOUT=8 instance, with an MTHI held during the busy period
        @(negedge clock);
        op_code = OP_DIV; op_a = 32'd5; op_b = 32'd3; op_valid_t = 1'b1;
        @(posedge clock); #1;
        c0 = cyc;
        op_code = OP_MTHI; op_a = 32'hCAFE_0001;
        n_tmo = 0; tmo_at = -1; done_a = -1; n_done = 0; ds = 0; ms = 0; early = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            ds += int'(div_start_t);
            ms += int'(mult_start_t);
            if (cyc == c0 + 5) check("tmo_busy", busy_t, 1);
            if (cyc < c0 + 11 && hi_t != 32'd0) early++;
            if (timeout_err_t) begin
                n_tmo++;
                if (tmo_at < 0) tmo_at = cyc;
                check("tmo_hilo", {hi_t, lo_t}, 64'd0);
                check("tmo_ready", op_ready_t, 1);
            end
            if (done_t) begin
                n_done++;
                done_a = cyc;
                op_valid_t = 1'b0;
            end
        end
        check("tmo_cycle", tmo_at, c0 + 10);
        check("tmo_count", n_tmo, 1);
        check("tmo_starts", {ms[7:0], ds[7:0]}, 16'h0001);
        check("held_early", early, 0);
        check("held_done", done_a, c0 + 11);
        check("held_count", n_done, 1);
        check("held_hilo", {hi_t, lo_t}, {32'hCAFE_0001, 32'd0});

        // Asynchronous reset while waiting on the multiplier
        do_op(OP_MTHI, 32'h5555_AAAA, 32'd0, 1);
        @(negedge clock);
        op_valid = 1'b1; op_code = OP_MULT; op_a = 32'd7; op_b = 32'd9;
        @(posedge clock); #1;
        op_valid = 1'b0;
        repeat (10) @(negedge clock);
        check("pre_rst_state", dbg_state, 3);
        #2;
        reset = 1'b1;
        #1;
        check("arst_state", dbg_state, 0);
        check("arst_hilo", {hi, lo}, 64'd0);
        check("arst_ready", op_ready, 1);
        check("arst_done", done, 0);
        @(negedge clock);
        reset = 1'b0;
        n_done = 0; ms = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            n_done += int'(done) + int'(timeout_err);
            ms += int'(mult_start);
        end
        check("post_rst_quiet", n_done + ms, 0);
        check("post_rst_hilo", {hi, lo}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_sched.md
# muldiv_sched

Sequencing controller for the multicycle CPU's shared multiply/divide resources. It accepts one HI/LO-class operation at a time from the main control unit and pulses the start input of the 32-cycle Booth multiplier or the divider. It then waits for that unit's end flag, commits the result into architectural HI/LO registers, and stalls the control unit while the operation is in flight. MTHI/MTLO writes are handled here too, so HI/LO has exactly one owner.

## Interface
- TIMEOUT, 64: maximum WAIT cycles before the operation is abandoned.
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- op_valid  in  1  request strobe. Sampled only when op_ready=1.
- op_code  in  2  operation select: 00 MULT, 01 DIV, 10 MTHI, 11 MTLO.
- op_a, op_b  in  32 each  operands. MTHI/MTLO use op_a only.
- op_ready  out  1  controller is idle and can accept a request.
- busy  out  1  stall request to control; equals ~op_ready.
- unit_a, unit_b  out  32 each  operands latched at accept, driven to both units.
- mult_start  out  1  one-cycle start pulse to the multiplier.
- mult_end  in  1  multiplier done flag (level; cleared by the unit on start).
- mult_hi, mult_lo  in  32 each  multiplier result.
- div_start  out  1  one-cycle start pulse to the divider.
- div_end  in  1  divider done flag (level; cleared by the unit on start).
- div_hi, div_lo  in  32 each  divider remainder and quotient.
- hi, lo  out  32 each  architectural HI and LO.
- done  out  1  one-cycle completion pulse.
- timeout_err  out  1  one-cycle pulse when an operation is abandoned.
- div_zero  out  1  one-cycle pulse, present only with DIVZERO_CHECK_EN.

## Operation
- States: IDLE, START, ARM, WAIT, DONE.
- IDLE
  - op_ready=1.
  - On op_valid=1 at an edge: latch op_a/op_b into unit_a/unit_b and latch op_code.
  - MULT/DIV go to START.
  - MTHI/MTLO write op_a into hi/lo at that same edge and go to DONE.
- START: exactly one of mult_start/div_start is 1, selected by the latched op; go to ARM.
- ARM
  - One cycle; the end inputs are ignored.
  - This guards against a stale end level left over from the previous operation.
  - Go to WAIT and clear the watchdog counter.
- WAIT
  - Watch only the selected unit's end flag; the other unit's flag is ignored.
  - At an edge with end=1: hi←unit_hi, lo←unit_lo, go to DONE.
  - Otherwise the counter increments.
  - When the counter reaches TIMEOUT: timeout_err pulses during the next cycle, hi/lo stay unchanged, go to IDLE.
- DONE: done=1 for one cycle, then go to IDLE.
- op_valid arriving while busy=1 is ignored. The requester holds op_valid until op_ready=1.
- unit_a/unit_b hold their values until the next accept.
- All outputs other than hi/lo/unit_a/unit_b are registered decodes of state.

## Timing
- Reset values: state IDLE, hi=0, lo=0, unit_a=0, unit_b=0, mult_start=0, div_start=0, done=0, timeout_err=0, div_zero=0, op_ready=1, busy=0.
- Reset is asynchronous.
  - Asserting it mid-operation aborts immediately; no done or error pulse follows.
  - The units share the same reset.
- Cycle numbering, with accept at edge E0:
  - START runs E0–E1 (start pulse high).
  - ARM runs E1–E2.
  - WAIT begins after E2.
- If the unit raises end after edge E(1+L), with L ≥ 1 edges counted from its start edge, then:
  - WAIT samples end at E(max(2, 1+L)+1).
  - hi/lo update at that edge.
  - done is high for the following cycle.
- Multiplier (end visible after its 32nd edge) gives done 35 cycles after accept.
- MTHI/MTLO: hi/lo update at E0, done is high in the E0–E1 cycle, and op_ready returns after E1.
- No request is accepted in the DONE cycle.
  - Back-to-back throughput for MTHI/MTLO is 1 op per 2 cycles.

## Configuration
- DIVZERO_CHECK_EN defined
  - A DIV accepted with op_b=0 skips START and goes directly to DONE.
  - div_zero=1 and done=1 in that cycle.
  - hi/lo unchanged; div_start never asserts.
- DIVZERO_CHECK_EN undefined
  - The div_zero port is absent.
  - A DIV with op_b=0 is started normally, and whatever the divider returns (or a timeout) is committed or reported.

## Test plan
- Reset
  - Stimulus: assert reset asynchronously mid-cycle while in WAIT.
  - Required: state IDLE immediately, hi=lo=0, op_ready=1, no done.
- MULT
  - Stimulus: op_a=0xFFFFFFFE (−2), op_b=3, Booth multiplier model attached.
  - Required: exactly one mult_start pulse; done 35 cycles after accept; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- DIV
  - Stimulus: op_a=100, op_b=7, behavioural divider with L=10.
  - Required: div_start pulse only; hi=2, lo=14; done at the computed cycle.
- MTHI then MTLO
  - Stimulus: MTHI with op_a=0x12345678, then MTLO with op_a=0x9ABCDEF0, each presented as soon as op_ready=1.
  - Required: each done 1 cycle after accept; hi/lo hold those values; no unit start.
- Timeout
  - Stimulus: TIMEOUT=8 and a divider whose div_end stays 0.
  - Required: timeout_err pulses once; hi/lo unchanged; op_ready=1 afterward; a request held during busy is accepted only afterward.
- Divide by zero
  - Stimulus: DIV with op_b=0, DIVZERO_CHECK_EN defined.
  - Required: div_zero and done both high in the cycle after accept; div_start never asserts; hi/lo unchanged.
